// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared load encodings, FSM states and the load legality check for wb_unit.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_WAIT_MEM
  } wb_state_e;

  // True for funct3 codes that are not loads, or for an access not aligned to its size.
  function automatic logic load_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'd0);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_unit_load_align.sv
// rtl/wb_unit_load_align.sv - combinational load lane select plus sign/zero extension.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_sel = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    err      = load_bad(funct3, addr_lo);
    data     = '0;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      F3_LW:   data = mem_rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - write-back stage owning the register-file write port.
// Optional WB_FWD_EN adds a combinational bypass view of the registered RF write.
module wb_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_NUM_BIT-1:0] in_rd,
  input  logic                   in_wen,
  input  logic [DATA_WIDTH-1:0]  in_result,
  input  logic                   in_is_load,
  input  logic [2:0]             in_funct3,
  input  logic [1:0]             in_addr_lo,
  input  logic                   mem_rvalid,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
`ifdef WB_FWD_EN
  output logic                   fwd_valid,
  output logic [REG_NUM_BIT-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]  fwd_data,
`endif
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  output logic                   wb_done,
  output logic                   wb_err
);

  wb_state_e              state_q, state_d;
  logic [REG_NUM_BIT-1:0] ld_rd_q, ld_rd_d;
  logic                   ld_wen_q, ld_wen_d;
  logic [2:0]             ld_f3_q, ld_f3_d;
  logic [1:0]             ld_lo_q, ld_lo_d;
  logic                   rf_wen_q, rf_wen_d;
  logic [REG_NUM_BIT-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
  logic                   wb_done_q, wb_done_d;
  logic                   wb_err_q, wb_err_d;
  logic [DATA_WIDTH-1:0]  align_data;
  logic                   align_err;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .mem_rdata (mem_rdata),
    .funct3    (ld_f3_q),
    .addr_lo   (ld_lo_q),
    .data      (align_data),
    .err       (align_err)
  );

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_wen_d   = ld_wen_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_done_d  = 1'b0;
    wb_err_d   = 1'b0;
    in_ready   = (state_q == WB_IDLE);
    case (state_q)
      WB_IDLE: begin
        if (in_valid && !in_is_load) begin
          rf_wen_d   = in_wen && (in_rd != '0);
          rf_waddr_d = in_rd;
          rf_wdata_d = in_result;
          wb_done_d  = 1'b1;
        end else if (in_valid) begin
          ld_rd_d  = in_rd;
          ld_wen_d = in_wen;
          ld_f3_d  = in_funct3;
          ld_lo_d  = in_addr_lo;
          state_d  = WB_WAIT_MEM;
        end
      end
      WB_WAIT_MEM: begin
        // A bad load still consumes its memory response so the handshake stays balanced.
        if (mem_rvalid) begin
          wb_done_d = 1'b1;
          state_d   = WB_IDLE;
          if (align_err) begin
            wb_err_d = 1'b1;
          end else begin
            rf_wen_d   = ld_wen_q && (ld_rd_q != '0);
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = align_data;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      ld_rd_q    <= '0;
      ld_wen_q   <= 1'b0;
      ld_f3_q    <= '0;
      ld_lo_q    <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_done_q  <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_wen_q   <= ld_wen_d;
      ld_f3_q    <= ld_f3_d;
      ld_lo_q    <= ld_lo_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_done_q  <= wb_done_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_done  = wb_done_q;
  assign wb_err   = wb_err_q;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_wen_q && (rf_waddr_q != '0);
  assign fwd_rd    = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;
`endif

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Write-back stage directly upstream of the register file. Owns the single RF write port (wen/waddr/wdata).
- Accepts retiring ops from the execute stage over a valid/ready handshake.
- ALU results are written straight through. Load results wait for the memory response, then are aligned and sign/zero-extended.
- RF write outputs are registered, so each write reaches the register file exactly one cycle after its data is known.

Parameters:
- DATA_WIDTH, 32, width of result, memory data and RF write data
- REG_NUM_BIT, 5, width of register index

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents a retiring op
- in_ready  out  1  wb_unit can accept an op this cycle
- in_rd  in  REG_NUM_BIT  destination register
- in_wen  in  1  op writes rd
- in_result  in  DATA_WIDTH  ALU/CSR/link result (ignored for loads)
- in_is_load  in  1  op is a load
- in_funct3  in  3  load width/sign code (RISC-V LB=0, LH=1, LW=2, LBU=4, LHU=5)
- in_addr_lo  in  2  load byte address bits [1:0]
- mem_rvalid  in  1  load data valid, single-cycle pulse
- mem_rdata  in  DATA_WIDTH  raw aligned 32-bit word from data memory
- rf_wen  out  1  register-file write enable
- rf_waddr  out  REG_NUM_BIT  register-file write index
- rf_wdata  out  DATA_WIDTH  register-file write data
- wb_done  out  1  one-cycle pulse when an op retires (written or not)
- wb_err  out  1  one-cycle pulse on an illegal or misaligned load

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. On rst: state=IDLE; rf_wen, rf_waddr, rf_wdata, wb_done, wb_err = 0; any pending load is discarded.
- FSM states:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
- Accept occurs when in_valid && in_ready.
- IDLE, accept, non-load:
  - Next cycle: rf_wen = in_wen && (in_rd!=0), rf_waddr=in_rd, rf_wdata=in_result, wb_done=1.
  - State stays IDLE. Back-to-back accepts allowed, giving 1 op/cycle throughput.
- IDLE, accept, load:
  - Latch rd, wen, funct3, addr_lo; go to WAIT_MEM. No RF write, no wb_done this cycle.
  - Misaligned or illegal load: LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or funct3 in {3,6,7}.
    - The load is still accepted and still waits for mem_rvalid, so the memory handshake stays balanced.
    - On retire: no write; wb_done=1 and wb_err=1.
- WAIT_MEM with mem_rvalid:
  - Next cycle: rf_wen = latched_wen && (rd!=0), rf_wdata = aligned(mem_rdata), wb_done=1. State returns to IDLE; in_ready=1 in that same cycle.
  - Load-to-RF-write latency: 1 cycle after mem_rvalid.
- Alignment:
  - LB/LBU select byte addr_lo. LH/LHU select halfword addr_lo[1].
  - LB/LH sign-extend to DATA_WIDTH; LBU/LHU zero-extend; LW passes through unchanged.
- rd==0 with in_wen=1 never asserts rf_wen. It retires normally (wb_done=1).
- mem_rvalid while in IDLE is ignored (spurious): no write, no pulse.
- in_valid while in WAIT_MEM is held off (in_ready=0). The execute stage must keep its inputs stable until accepted.
- rf_wen, wb_done and wb_err deassert one cycle after assertion unless a new retire occurs.
- Reset mid-WAIT_MEM: the pending load is dropped; a mem_rvalid arriving after reset release is ignored.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (REG_NUM_BIT), fwd_data (DATA_WIDTH), driven combinationally from the current rf_wen/rf_waddr/rf_wdata registers.
  - fwd_valid = rf_wen. Decode can bypass the value being written this cycle, before the RF holds it.
  - fwd_valid is 0 whenever rf_waddr==0.
- Undefined: these ports do not exist; no logic is generated.

Decomposition:
- Package wb_pkg: funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), state enum {WB_IDLE, WB_WAIT_MEM}, and the load misalign/illegal predicate as a function.
- One natural sub-module: load_align, purely combinational (mem_rdata, funct3, addr_lo -> data, err). It is instantiated once and unit-tested separately.

Test Plan:
- ALU write: accept in_rd=5, in_wen=1, in_result=0x1234_5678 at cycle N -> at N+1, rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, wb_done=1; at N+2, rf_wen=0.
- x0 suppression: in_rd=0, in_wen=1, in_result=0xFFFF_FFFF -> rf_wen stays 0, wb_done=1.
- LB sign-extend: load rd=7, funct3=0, addr_lo=2; mem_rvalid 3 cycles later with mem_rdata=0x0080_0000 -> in_ready=0 while waiting; one cycle after mem_rvalid, rf_wdata=0xFFFF_FF80, rf_waddr=7.
- LHU/LW: funct3=5, addr_lo=2, mem_rdata=0xBEEF_0000 -> rf_wdata=0x0000_BEEF; funct3=2, addr_lo=0, mem_rdata=0xDEAD_BEEF -> rf_wdata=0xDEADBEEF.
- Misaligned: LW with addr_lo=1, then mem_rvalid -> rf_wen=0, wb_done=1, wb_err=1 for exactly one cycle; the next ALU op is accepted in the same cycle.
- Reset mid-load: assert rst in WAIT_MEM, release, then pulse mem_rvalid -> no rf_wen, no wb_done, in_ready=1 immediately after release.
